vector_sequencer: RTL and testbench
===================================

Name: vector_sequencer

Overview:
- Self-checking stimulus sequencer for the small combinational datapath blocks in the processor bring-up flow (3 inputs a/b/c, 1 output y).
- Holds a loadable table of test vectors {a,b,c,y_expected} and applies them to the datapath one at a time.
- Samples y after a programmable settle time, then counts mismatches and records the first failing index.
- Replaces hand-written delay/assert sequences with a clocked, reusable controller usable in simulation and on FPGA.

Parameters:
- NVEC, 8, vector table depth; must be a power of 2.
- AW, 3, table address width; equals log2(NVEC).
- SETTLE, 2, cycles a vector is held before the check cycle; minimum 1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin run; accepted only in IDLE or DONE
- num_vec  in  AW+1  vectors to run (0..NVEC); latched on accepted start; values >NVEC clamp to NVEC
- cfg_we  in  1  table write enable; ignored while busy
- cfg_addr  in  AW  table write address
- cfg_wdata  in  4  {a,b,c,y_exp} in bits [3:0], a=bit3
- dut_a, dut_b, dut_c  out  1 each  registered stimulus to the datapath
- dut_y  in  1  datapath output
- busy  out  1  run in progress
- done  out  1  run complete; held until the next accepted start or reset
- err_count  out  AW+1  mismatch count for the current or last run
- fail_valid  out  1  at least one mismatch seen
- first_fail_idx  out  AW  index of the first mismatch; valid when fail_valid=1
- pass  out  1  done & ~fail_valid

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, pass, fail_valid = 0; dut_a/b/c = 0; err_count = 0; first_fail_idx = 0; index and settle counters = 0.
  - Table contents are not reset and are retained.
  - Reset mid-run aborts the run immediately; the next edge with reset_n=1 is in IDLE.
- Table write: on an edge with cfg_we=1 and busy=0, table[cfg_addr] <= cfg_wdata. Writes while busy are dropped.
- FSM states: IDLE, DRIVE, CHECK, DONE.
- IDLE/DONE, start=1:
  - Latch the clamped num_vec; clear err_count, fail_valid, first_fail_idx, done; set idx=0.
  - If num_vec=0: go to DONE with done=1, pass=1, one cycle after start.
  - Otherwise: go to DRIVE with dut_* <= table[0][3:1] and busy=1.
- DRIVE: hold dut_*; stay SETTLE cycles (counter 0..SETTLE-1), then go to CHECK.
- CHECK:
  - dut_* remain held.
  - Compare dut_y to table[idx][0]. A mismatch is any difference, including X/Z on dut_y in simulation (4-state compare).
  - On mismatch: err_count increments, saturating at 2^(AW+1)-1. If fail_valid=0, record first_fail_idx <= idx and set fail_valid=1.
  - If idx = num_vec-1: go to DONE (busy=0, done=1).
  - Otherwise: idx++, dut_* <= table[idx+1][3:1], go to DRIVE.
- Timing:
  - Each vector occupies exactly SETTLE+1 cycles.
  - done rises num_vec*(SETTLE+1) cycles after the start-accept edge.
  - dut_* change only on the edge entering DRIVE.
- start while busy is ignored; it has no effect on the current run.
- start in DONE begins a fresh run. dut_* keep their last vector until the new vector is applied.
- Status outputs (err_count, fail_valid, first_fail_idx, pass) are stable in DONE.

Optional Feature:
- Macro: VECTOR_SEQ_HALT_ON_ERROR_EN.
- Defined: the first mismatch in CHECK ends the run. The FSM goes to DONE with err_count=1 and remaining vectors skipped; done rises (k+1)*(SETTLE+1) cycles after start for a failure at index k.
- Undefined: all num_vec vectors always run and every mismatch is counted.

Test Plan:
- Golden model y=~b&(a|~c). Load all 8 vectors with correct y_exp (000→1, 001→0, 010→0, 011→0, 100→1, 101→1, 110→0, 111→0); num_vec=8, SETTLE=2 -> done after 24 cycles, err_count=0, pass=1, fail_valid=0; dut_* step through 000..111 each held 3 cycles.
- Same setup, but table[5] y_exp=0 and table[7] y_exp=1 -> err_count=2, fail_valid=1, first_fail_idx=5, pass=0. With VECTOR_SEQ_HALT_ON_ERROR_EN defined: err_count=1, done 18 cycles after start.
- num_vec=0 -> done=1, pass=1 one cycle after start, busy never asserts, dut_* unchanged. num_vec=12 -> clamped, 8 vectors run, done at 24 cycles.
- During run: start=1 at vector 3, and cfg_we=1 writing table[6]=4'b1111 -> run unaffected (done at 24, err_count=0); table[6] still holds the original value on a rerun.
- reset_n=0 for 1 cycle while idx=3 with one mismatch already counted -> next cycle busy=0, done=0, err_count=0, fail_valid=0, dut_*=000. A subsequent start reruns from idx 0 with the retained table and gives the same results as the first scenario.
- dut_y forced to X on vector 2 -> counted as mismatch: err_count=1, first_fail_idx=2.

Source files
------------

// File: rtl/vector_sequencer.sv
// vector_sequencer: table-driven stimulus/check controller for 3-in/1-out datapaths.
// Optional `VECTOR_SEQ_HALT_ON_ERROR_EN: end the run at the first mismatch.
module vector_sequencer #(
  parameter int NVEC   = 8,
  parameter int AW     = 3,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW:0]   num_vec,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [3:0]    cfg_wdata,
  output logic          dut_a,
  output logic          dut_b,
  output logic          dut_c,
  input  logic          dut_y,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   err_count,
  output logic          fail_valid,
  output logic [AW-1:0] first_fail_idx,
  output logic          pass
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    CHECK,
    DONE
  } state_t;

  state_t        state;
  logic [3:0]    tbl [NVEC];
  logic [AW:0]   nvec;
  logic [AW-1:0] idx;
  logic [AW-1:0] nxt_idx;
  logic [CW-1:0] cnt;
  logic [AW:0]   num_clamped;
  logic          miss;
  logic          last;
  logic          stop;

  // Clamp request, mismatch detection and end-of-run decision
  always_comb begin
    num_clamped = num_vec;
    if (num_vec > (AW+1)'(NVEC))
      num_clamped = (AW+1)'(NVEC);
    nxt_idx = idx + 1'b1;
    // 4-state compare so an X/Z response counts as a failure
    miss = (dut_y !== tbl[idx][0]);
    last = ({1'b0, idx} == nvec - 1'b1);
`ifdef VECTOR_SEQ_HALT_ON_ERROR_EN
    stop = last | miss;
`else
    stop = last;
`endif
  end

  // Vector table: written only while no run is active, never reset
  always_ff @(posedge clk) begin
    if (cfg_we && !busy)
      tbl[cfg_addr] <= cfg_wdata;
  end

  // Run controller with registered stimulus and status
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      nvec           <= '0;
      idx            <= '0;
      cnt            <= '0;
      dut_a          <= 1'b0;
      dut_b          <= 1'b0;
      dut_c          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_idx <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            nvec           <= num_clamped;
            idx            <= '0;
            cnt            <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            if (num_clamped == '0) begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= DRIVE;
              done  <= 1'b0;
              pass  <= 1'b0;
              busy  <= 1'b1;
              {dut_a, dut_b, dut_c} <= tbl[0][3:1];
            end
          end
        end
        DRIVE: begin
          if (cnt == CW'(SETTLE - 1)) begin
            cnt   <= '0;
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (miss) begin
            if (err_count != '1)
              err_count <= err_count + 1'b1;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_idx <= idx;
            end
          end
          if (stop) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ~(fail_valid | miss);
          end else begin
            idx   <= nxt_idx;
            state <= DRIVE;
            {dut_a, dut_b, dut_c} <= tbl[nxt_idx][3:1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// tb_vector_sequencer: scoreboard bench for vector_sequencer.
// Reference model derives each run's outcome from the table contents.
module tb_vector_sequencer;

  localparam int S = 2;
  localparam int VL = S + 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] num_vec;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [3:0] cfg_wdata;
  logic       dut_a, dut_b, dut_c;
  logic       dut_y;
  logic       busy, done, fail_valid, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail_idx;

  vector_sequencer #(.NVEC(8), .AW(3), .SETTLE(S)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_vec(num_vec),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_y(dut_y),
    .busy(busy), .done(done), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_idx(first_fail_idx), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int err;
    int fv;
    int ffi;
    int pas;
    int last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   pending = 0;
  int   tbl_m [8];
  int   cur_last = 0;
  bit   flip_en = 0;
  logic [2:0] fpat = 3'b000;
  bit   x_en = 0;
  logic [2:0] xpat = 3'b000;
  logic probe;

  function automatic logic gold(logic [2:0] v);
    return ~v[1] & (v[2] | ~v[0]);
  endfunction

  // Golden datapath, with optional inverted or X response on one pattern
  always_comb begin
    dut_y = gold({dut_a, dut_b, dut_c});
    if (flip_en && {dut_a, dut_b, dut_c} == fpat)
      dut_y = ~dut_y;
    if (x_en && {dut_a, dut_b, dut_c} == xpat)
      dut_y = 1'bx;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected outcome of a run over the current model table
  task automatic predict(int n_raw, output exp_t e);
    int n;
    logic [2:0] v;
    logic y;
    bit mis;
    n = (n_raw > 8) ? 8 : n_raw;
    e.lat = n * VL;
    e.err = 0;
    e.fv = 0;
    e.ffi = 0;
    for (int i = 0; i < n; i++) begin
      v = 3'(tbl_m[i] >> 1);
      y = gold(v) ^ (flip_en && v == fpat);
      mis = (x_en && v == xpat) || (y != tbl_m[i][0]);
      cur_last = int'(v);
      if (mis) begin
        if (e.fv == 0) begin
          e.fv = 1;
          e.ffi = i;
        end
        e.err++;
`ifdef VECTOR_SEQ_HALT_ON_ERROR_EN
        e.lat = (i + 1) * VL;
        break;
`endif
      end
    end
    e.pas = (e.fv == 0);
    e.last = cur_last;
  endtask

  task automatic write_tbl(int a, int d);
    cfg_we = 1'b1;
    cfg_addr = 3'(a);
    cfg_wdata = 4'(d);
    tick();
    cfg_we = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic load_golden;
    for (int i = 0; i < 8; i++)
      write_tbl(i, (i << 1) | int'(gold(3'(i))));
  endtask

  task automatic launch(int n);
    exp_t e;
    predict(n, e);
    sbq.push_back(e);
    start = 1'b1;
    num_vec = 4'(n);
    tick();
    start = 1'b0;
    acc_cyc = cyc;
    pending = 1;
  endtask

  task automatic wait_run;
    for (int k = 0; k < 400 && pending; k++)
      tick();
    if (pending) begin
      checks++;
      failures++;
      $display("FAIL run_timeout: done not seen within 400 cycles");
      pending = 0;
      void'(sbq.pop_front());
    end
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fail_valid"}, fail_valid, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_fail_idx"}, first_fail_idx, 0);
    chk({tag, "_dut_abc"}, {dut_a, dut_b, dut_c}, 0);
  endtask

  // Monitor: per-cycle stimulus tracking and end-of-run scoreboard compare
  always @(negedge clk) begin
    int t;
    int vi;
    exp_t e;
    if (pending) begin
      t = cyc - acc_cyc;
      if (done) begin
        pending = 0;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: done with no expected run queued");
        end else begin
          e = sbq.pop_front();
          chk("latency", t, e.lat);
          chk("err_count", err_count, e.err);
          chk("fail_valid", fail_valid, e.fv);
          chk("first_fail_idx", first_fail_idx, e.ffi);
          chk("pass", pass, e.pas);
          chk("busy_at_done", busy, 0);
          chk("dut_abc_at_done", {dut_a, dut_b, dut_c}, e.last);
        end
      end else begin
        vi = t / VL;
        chk("busy_in_run", busy, 1);
        if (vi < 8)
          chk("dut_abc_step", {dut_a, dut_b, dut_c}, tbl_m[vi] >> 1);
        else
          chk("run_overlong", vi, 7);
      end
    end
  end

  initial begin
    exp_t junk;
    probe = 1'bx;
    reset_n = 1'b0;
    start = 1'b0;
    num_vec = '0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    for (int i = 0; i < 8; i++) tbl_m[i] = 0;
    tick();
    tick();
    check_reset_state("reset");
    reset_n = 1'b1;
    tick();

    // Full golden table, all 8 vectors
    load_golden();
    launch(8);
    wait_run();

    // Two corrupted expectations at 5 and 7
    write_tbl(5, (5 << 1) | 0);
    write_tbl(7, (7 << 1) | 1);
    launch(8);
    wait_run();
    load_golden();

    // Empty run and clamped oversize run
    launch(0);
    wait_run();
    chk("n0_pass_hold", pass, 1);
    launch(12);
    wait_run();

    // Start and table write while busy must be ignored
    launch(8);
    repeat (10) tick();
    start = 1'b1;
    num_vec = 4'd1;
    cfg_we = 1'b1;
    cfg_addr = 3'd6;
    cfg_wdata = 4'hF;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    wait_run();
    launch(8);
    wait_run();

    // Reset in the middle of a run with one mismatch already counted
    flip_en = 1;
    fpat = 3'b001;
    launch(8);
    repeat (10) tick();
    chk("midrun_err_count", err_count, 1);
    reset_n = 1'b0;
    tick();
    pending = 0;
    void'(sbq.pop_front());
    cur_last = 0;
    check_reset_state("midrun_reset");
    reset_n = 1'b1;
    flip_en = 0;
    launch(8);
    wait_run();

    // X response on vector 2 (only meaningful on a 4-state simulator)
    if (probe === 1'bx) begin
      x_en = 1;
      xpat = 3'b010;
      launch(8);
      wait_run();
      x_en = 0;
    end

    // Randomized tables, error injection and run lengths
    for (int r = 0; r < 30; r++) begin
      int nw;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++) begin
        int a;
        int v;
        int y;
        a = $urandom_range(0, 7);
        v = $urandom_range(0, 7);
        y = int'(gold(3'(v)));
        if ($urandom_range(0, 3) == 0) y = 1 - y;
        write_tbl(a, (v << 1) | y);
      end
      flip_en = ($urandom_range(0, 4) == 0);
      fpat = 3'($urandom_range(0, 7));
      launch($urandom_range(0, 15));
      wait_run();
      flip_en = 0;
    end

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_leftover: %0d runs never completed, expected 0", sbq.size());
    end
    junk.lat = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
